graycode_decoder_3bit_sync: RTL and testbench
=============================================

Name: graycode_decoder_3bit_sync

Overview:
- Clocked decoder from 3-bit Gray code back to 7-bit thermometer code and binary. It is the receive-side counterpart of the team's thermometer-to-Gray encoder.
- Filters glitches on the incoming Gray bus: a code is committed only after it is stable for a set number of valid samples.
- Optionally flags illegal multi-bit steps and reports step direction.
- Sits between an asynchronous position/level source and downstream synchronous logic.

Parameters:
- GRAY_W, 3, Gray code width. THERM_W = 2**GRAY_W-1 is derived, not overridable.
- STABLE_CYCLES, 2, number of consecutive identical valid samples required to commit a code. Legal range is 1..15.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  block enable; 0 forces outputs to zero
- in_valid  in  1  gray_in is sampled this cycle
- gray_in  in  GRAY_W  Gray code input
- err_clr  in  1  clears step_err
- therm_out  out  THERM_W  committed thermometer code, registered
- bin_out  out  GRAY_W  committed binary value, registered
- out_valid  out  1  one-cycle pulse when a new code commits
- dir_up  out  1  1 = last committed step was +1 (mod 8); 0 = -1
- step_err  out  1  sticky: a committed step changed more than one Gray bit

Behaviour:
- Reset (rst_n=0, asynchronous):
  - therm_out=0, bin_out=0, out_valid=0, dir_up=0, step_err=0.
  - FSM returns to S_IDLE; candidate=0; counter=0; have_prev=0.
- Decoding:
  - bin[MSB]=g[MSB]; bin[i]=bin[i+1]^g[i].
  - therm = (1<<bin)-1. Examples: Gray 000 -> 0000000, 010 -> 0000111, 100 -> 1111111.
- FSM states: S_IDLE, S_SETTLE, S_LOCKED.
  - S_IDLE: entered on reset or when enable=0. Outputs are driven to 0 (therm, bin, out_valid) and have_prev is cleared. When enable=1 && in_valid, load candidate=gray_in and counter=1, then go to S_SETTLE (or commit immediately if STABLE_CYCLES=1).
  - S_SETTLE: on a valid sample equal to candidate, counter++. When counter reaches STABLE_CYCLES, commit. On a valid sample different from candidate, reload candidate, set counter=1, stay in S_SETTLE.
  - S_LOCKED: committed code held. A valid sample equal to the committed code is ignored. A different sample goes to S_SETTLE with that candidate and counter=1.
- Cycles with in_valid=0 neither advance nor reset the counter.
- Commit (a single clock edge):
  - therm_out and bin_out update; out_valid=1 for exactly the next cycle; state goes to S_LOCKED; have_prev=1.
  - A commit equal to the current committed code does not pulse out_valid. This only happens when returning to the same code after a glitch.
- Latency: outputs change at the edge that takes the STABLE_CYCLES-th consecutive identical valid sample. With the default, that is 2 valid cycles after the code appears.
- enable falling mid-settle: candidate is discarded and outputs are zeroed on the next edge. step_err holds its value.
- err_clr and a new error in the same cycle: the set wins.
- Wrap-around: bin 7 -> 0 (Gray 100 -> 000) is a legal +1 step with dir_up=1. bin 0 -> 7 is a legal -1 step.

Optional Feature:
- Macro GRAY_STEP_CHECK_EN.
- Defined:
  - On each commit with have_prev=1, compute the Hamming distance between the old and new Gray codes.
  - Distance != 1 sets step_err. committed bin/therm still update.
  - dir_up = (new_bin == old_bin+1 mod 2**GRAY_W). On an erroneous step dir_up keeps its previous value.
- Undefined:
  - step_err and dir_up are tied to 0, err_clr is ignored, and no comparison logic is built.

Decomposition:
- graycode_pkg holds:
  - GRAY_W default and the derived THERM_W
  - the state encoding (S_IDLE=2'd0, S_SETTLE=2'd1, S_LOCKED=2'd2)
  - the gray2bin and bin2therm functions
- One sub-module, graycode_stability_filter: candidate register, counter, and commit strobe. The top level keeps the FSM glue, decode, and step check.

Test Plan:
- Up sweep: Gray 000,001,011,010,110,111,101,100, each held 2 valid cycles -> therm goes 0000000, 0000001, ... 1111111; 8 out_valid pulses; dir_up=1; step_err=0.
- Glitch rejection: locked at Gray 011, apply 1 cycle of 111, then 011 again -> no out_valid pulse; therm stays 0000011.
- Wrap: locked at Gray 100 (bin 7), apply 000 for 2 cycles -> bin_out=0, dir_up=1, step_err=0. Then apply 100 -> bin_out=7, dir_up=0.
- Step error (macro on): from Gray 000 apply 011 -> bin_out=2, step_err=1. err_clr for 1 cycle -> step_err=0. Macro off -> step_err stays 0.
- enable drop mid-settle, then re-enable:
  - enable=0 on the cycle after a new sample -> next edge therm_out=0, no out_valid pulse.
  - Re-enable with Gray 110 held 2 valid cycles -> commit with no step_err, because have_prev was cleared.
- Reset mid-operation: rst_n low asynchronously while in S_SETTLE -> all outputs 0 immediately. After release, the first commit requires a full STABLE_CYCLES valid samples.

Source files
------------

// File: rtl/graycode_pkg.sv
// Shared types and helpers for the 3-bit Gray-code decoder: default widths,
// FSM state encoding and the Gray->binary->thermometer conversion functions.
package graycode_pkg;

  localparam int GRAY_W_DEFAULT  = 3;
  localparam int THERM_W_DEFAULT = 2**GRAY_W_DEFAULT - 1;
  // Wide enough for the full legal STABLE_CYCLES range of 1..15.
  localparam int CNT_W           = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  function automatic logic [GRAY_W_DEFAULT-1:0] gray2bin(input logic [GRAY_W_DEFAULT-1:0] g);
    logic [GRAY_W_DEFAULT-1:0] b;
    b[GRAY_W_DEFAULT-1] = g[GRAY_W_DEFAULT-1];
    for (int i = GRAY_W_DEFAULT-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [THERM_W_DEFAULT-1:0] bin2therm(input logic [GRAY_W_DEFAULT-1:0] b);
    logic [THERM_W_DEFAULT-1:0] t;
    for (int i = 0; i < THERM_W_DEFAULT; i++) t[i] = (i < int'(b));
    return t;
  endfunction

endpackage

// File: rtl/graycode_stability_filter.sv
// Glitch filter for the Gray decoder: holds the candidate code and the length of its
// current run of accepted samples, and strobes commit on the sample that completes it.
module graycode_stability_filter
  import graycode_pkg::*;
#(
  parameter int W             = GRAY_W_DEFAULT,
  parameter int STABLE_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         settling,
  input  logic         take,
  input  logic [W-1:0] sample,
  output logic         commit
);

  localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(STABLE_CYCLES);

  logic [W-1:0]     candidate;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] cnt_next;

  // Outside S_SETTLE every accepted sample starts a fresh run of one.
  always_comb begin
    cnt_next = (settling && (sample == candidate)) ? counter + 1'b1 : CNT_W'(1);
    commit   = take && (cnt_next == STABLE_CNT);
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      candidate <= '0;
      counter   <= '0;
    end else if (flush) begin
      candidate <= '0;
      counter   <= '0;
    end else if (take) begin
      candidate <= sample;
      counter   <= cnt_next;
    end
  end

endmodule

// File: rtl/graycode_decoder_3bit_sync.sv
// Clocked 3-bit Gray-code to thermometer/binary decoder with glitch filtering.
// Define GRAY_STEP_CHECK_EN to build the illegal-step flag and step-direction output.
module graycode_decoder_3bit_sync
  import graycode_pkg::*;
#(
  parameter  int GRAY_W        = GRAY_W_DEFAULT,
  parameter  int STABLE_CYCLES = 2,
  localparam int THERM_W       = 2**GRAY_W - 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               in_valid,
  input  logic [GRAY_W-1:0]  gray_in,
  input  logic               err_clr,
  output logic [THERM_W-1:0] therm_out,
  output logic [GRAY_W-1:0]  bin_out,
  output logic               out_valid,
  output logic               dir_up,
  output logic               step_err
);

  state_t            state;
  logic [GRAY_W-1:0] cur_gray;
  logic              have_prev;
  logic              locked_same;
  logic              take;
  logic              commit;
  logic              new_code;

  // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
  always_comb begin
    locked_same = (state == S_LOCKED) && (gray_in == cur_gray);
    take        = enable && in_valid && !locked_same;
    new_code    = !have_prev || (gray_in != cur_gray);
  end

  graycode_stability_filter #(
    .W             (GRAY_W),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_filter (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (!enable),
    .settling (state == S_SETTLE),
    .take     (take),
    .sample   (gray_in),
    .commit   (commit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cur_gray  <= '0;
      have_prev <= 1'b0;
      therm_out <= '0;
      bin_out   <= '0;
      out_valid <= 1'b0;
    end else if (!enable) begin
      state     <= S_IDLE;
      cur_gray  <= '0;
      have_prev <= 1'b0;
      therm_out <= '0;
      bin_out   <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (commit) begin
        state     <= S_LOCKED;
        cur_gray  <= gray_in;
        have_prev <= 1'b1;
        bin_out   <= gray2bin(gray_in);
        therm_out <= bin2therm(gray2bin(gray_in));
        // Re-committing the held code after a glitch is not a new event.
        out_valid <= new_code;
      end else if (take) begin
        state <= S_SETTLE;
      end
    end
  end

`ifdef GRAY_STEP_CHECK_EN
  logic              is_step;
  logic              bad_step;
  logic [GRAY_W-1:0] new_bin;

  always_comb begin
    new_bin  = gray2bin(gray_in);
    is_step  = commit && have_prev && (gray_in != cur_gray);
    bad_step = is_step && ($countones(gray_in ^ cur_gray) != 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_err <= 1'b0;
      dir_up   <= 1'b0;
    end else begin
      // A fresh error outranks a simultaneous clear.
      if (bad_step)     step_err <= 1'b1;
      else if (err_clr) step_err <= 1'b0;
      if (is_step && !bad_step) dir_up <= (new_bin == bin_out + 1'b1);
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign step_err       = 1'b0;
  assign dir_up         = 1'b0;
`endif

endmodule

// File: tb/tb_graycode_decoder_3bit_sync.sv
// Self-checking bench for graycode_decoder_3bit_sync: directed vector table, hand-written
// corner sequences and randomized traffic against a run-length reference model.
module tb_graycode_decoder_3bit_sync;

  localparam int STABLE = 2;
`ifdef GRAY_STEP_CHECK_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       in_valid;
  logic [2:0] gray_in;
  logic       err_clr;
  logic [6:0] therm_out;
  logic [2:0] bin_out;
  logic       out_valid;
  logic       dir_up;
  logic       step_err;

  graycode_decoder_3bit_sync #(
    .GRAY_W        (3),
    .STABLE_CYCLES (STABLE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .in_valid  (in_valid),
    .gray_in   (gray_in),
    .err_clr   (err_clr),
    .therm_out (therm_out),
    .bin_out   (bin_out),
    .out_valid (out_valid),
    .dir_up    (dir_up),
    .step_err  (step_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: a code commits when its run of identical valid samples reaches STABLE.
  int         m_run;
  logic [2:0] m_last;
  logic [2:0] m_cgray;
  logic [2:0] m_bin;
  logic [6:0] m_therm;
  logic       m_have;
  logic       m_ov;
  logic       m_dir;
  logic       m_err;

  function automatic int bin_of(input logic [2:0] g);
    for (int k = 0; k < 8; k++) if (3'(k ^ (k >> 1)) == g) return k;
    return 0;
  endfunction

  function automatic int hamming(input logic [2:0] a, input logic [2:0] b);
    int d;
    d = 0;
    for (int i = 0; i < 3; i++) if (a[i] != b[i]) d++;
    return d;
  endfunction

  task automatic model_reset();
    m_run = 0; m_last = '0; m_cgray = '0; m_bin = '0; m_therm = '0;
    m_have = 1'b0; m_ov = 1'b0; m_dir = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_step(input logic en, input logic vld, input logic [2:0] g, input logic clr);
    bit set_err;
    int nb;
    set_err = 1'b0;
    m_ov    = 1'b0;
    if (!en) begin
      m_run = 0; m_have = 1'b0; m_bin = '0; m_therm = '0;
    end else if (vld) begin
      if (m_run > 0 && g == m_last) m_run++;
      else begin m_run = 1; m_last = g; end
      if (m_run == STABLE) begin
        nb = bin_of(g);
        if (!m_have || g != m_cgray) m_ov = 1'b1;
        if (STEP_EN && m_have && g != m_cgray) begin
          if (hamming(g, m_cgray) != 1) set_err = 1'b1;
          else m_dir = (nb == (int'(m_bin) + 1) % 8);
        end
        m_bin = 3'(nb); m_therm = 7'((1 << nb) - 1); m_cgray = g; m_have = 1'b1;
      end
    end
    if (STEP_EN) begin
      if (set_err) m_err = 1'b1;
      else if (clr) m_err = 1'b0;
    end
  endtask

  // Called at a falling edge: drive, take the rising edge, return at the next falling edge.
  task automatic drive(input logic en, input logic vld, input logic [2:0] g, input logic clr);
    enable = en; in_valid = vld; gray_in = g; err_clr = clr;
    @(posedge clk);
    model_step(en, vld, g, clr);
    @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_therm"}, 32'(therm_out), 32'(m_therm));
    check({tag, "_bin"},   32'(bin_out),   32'(m_bin));
    check({tag, "_ov"},    32'(out_valid), 32'(m_ov));
    check({tag, "_dir"},   32'(dir_up),    32'(m_dir));
    check({tag, "_err"},   32'(step_err),  32'(m_err));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_therm"}, 32'(therm_out), 32'h0);
    check({tag, "_bin"},   32'(bin_out),   32'h0);
    check({tag, "_ov"},    32'(out_valid), 32'h0);
    check({tag, "_dir"},   32'(dir_up),    32'h0);
    check({tag, "_err"},   32'(step_err),  32'h0);
  endtask

  typedef struct {
    logic       en;
    logic       vld;
    logic [2:0] g;
    logic       clr;
    logic [6:0] therm;
    logic [2:0] bin;
    logic       ov;
    logic       dir;
    logic       err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic en, input logic vld, input logic [2:0] g, input logic clr,
                     input logic [6:0] therm, input logic [2:0] bin, input logic ov,
                     input logic dir, input logic err);
    vec_t v;
    v.en = en; v.vld = vld; v.g = g; v.clr = clr;
    v.therm = therm; v.bin = bin; v.ov = ov; v.dir = dir; v.err = err;
    vecs.push_back(v);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [2:0] g_hold;
    // Up sweep, two valid samples per code; dir/err columns apply with step checking built.
    add(1,1,3'b000,0, 7'h00,3'd0,0,0,0); add(1,1,3'b000,0, 7'h00,3'd0,1,0,0);
    add(1,1,3'b001,0, 7'h00,3'd0,0,0,0); add(1,1,3'b001,0, 7'h01,3'd1,1,1,0);
    add(1,1,3'b011,0, 7'h01,3'd1,0,1,0); add(1,1,3'b011,0, 7'h03,3'd2,1,1,0);
    add(1,1,3'b010,0, 7'h03,3'd2,0,1,0); add(1,1,3'b010,0, 7'h07,3'd3,1,1,0);
    add(1,1,3'b110,0, 7'h07,3'd3,0,1,0); add(1,1,3'b110,0, 7'h0F,3'd4,1,1,0);
    add(1,1,3'b111,0, 7'h0F,3'd4,0,1,0); add(1,1,3'b111,0, 7'h1F,3'd5,1,1,0);
    add(1,1,3'b101,0, 7'h1F,3'd5,0,1,0); add(1,1,3'b101,0, 7'h3F,3'd6,1,1,0);
    add(1,1,3'b100,0, 7'h3F,3'd6,0,1,0); add(1,1,3'b100,0, 7'h7F,3'd7,1,1,0);
    // Wrap 7 -> 0 (up), back 0 -> 7 (down), then 7 -> 0 with an invalid gap mid-settle.
    add(1,1,3'b000,0, 7'h7F,3'd7,0,1,0); add(1,1,3'b000,0, 7'h00,3'd0,1,1,0);
    add(1,1,3'b100,0, 7'h00,3'd0,0,1,0); add(1,1,3'b100,0, 7'h7F,3'd7,1,0,0);
    add(1,1,3'b000,0, 7'h7F,3'd7,0,0,0); add(1,0,3'b011,0, 7'h7F,3'd7,0,0,0);
    add(1,1,3'b000,0, 7'h00,3'd0,1,1,0);
    // Two-bit step 000 -> 011, then err_clr.
    add(1,1,3'b011,0, 7'h00,3'd0,0,1,0); add(1,1,3'b011,0, 7'h03,3'd2,1,1,1);
    add(1,0,3'b011,1, 7'h03,3'd2,0,1,0);
    // Glitch to 111 for one sample while locked at 011.
    add(1,1,3'b111,0, 7'h03,3'd2,0,1,0); add(1,1,3'b011,0, 7'h03,3'd2,0,1,0);
    add(1,1,3'b011,0, 7'h03,3'd2,0,1,0); add(1,1,3'b011,0, 7'h03,3'd2,0,1,0);

    rst_n = 1'b0; enable = 1'b0; in_valid = 1'b0; gray_in = '0; err_clr = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].vld, vecs[i].g, vecs[i].clr);
      check($sformatf("vec%0d_therm", i), 32'(therm_out), 32'(vecs[i].therm));
      check($sformatf("vec%0d_bin", i),   32'(bin_out),   32'(vecs[i].bin));
      check($sformatf("vec%0d_ov", i),    32'(out_valid), 32'(vecs[i].ov));
      check($sformatf("vec%0d_dir", i),   32'(dir_up),    32'(vecs[i].dir & STEP_EN));
      check($sformatf("vec%0d_err", i),   32'(step_err),  32'(vecs[i].err & STEP_EN));
    end

    // Enable drops the cycle after a new sample, then re-enable at 110 (two bits from 011).
    drive(1, 1, 3'b010, 0); check_model("endrop_settle");
    drive(0, 1, 3'b010, 0); check_model("endrop_off");
    check("endrop_therm_zero", 32'(therm_out), 32'h0);
    drive(1, 1, 3'b110, 0); check_model("reen_first");
    drive(1, 1, 3'b110, 0); check_model("reen_commit");
    check("reen_bin", 32'(bin_out), 32'd4);
    check("reen_ov", 32'(out_valid), 32'd1);
    check("reen_no_err", 32'(step_err), 32'd0);

    // Illegal step committing in the same cycle as err_clr: the set wins.
    drive(1, 1, 3'b000, 0); check_model("setwin_first");
    drive(1, 1, 3'b000, 1); check_model("setwin_commit");
    check("setwin_err", 32'(step_err), 32'(STEP_EN));
    drive(1, 0, 3'b000, 1); check_model("setwin_clr");

    // Asynchronous reset while settling, then a full-length settle afterwards.
    drive(1, 1, 3'b111, 0); check_model("rst_settle");
    #2 rst_n = 1'b0;
    #1 check_zero("rst_async");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 1, 3'b111, 0); check_model("rst_first");
    check("rst_first_ov", 32'(out_valid), 32'd0);
    drive(1, 1, 3'b111, 0); check_model("rst_commit");
    check("rst_commit_therm", 32'(therm_out), 32'h1F);

    g_hold = 3'b111;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0) g_hold = 3'($urandom_range(0, 7));
      drive(($urandom_range(0, 19) != 0), ($urandom_range(0, 3) != 0), g_hold,
            ($urandom_range(0, 11) == 0));
      check_model($sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
